// File: rtl/four_bit_add.sv
// -----------------------------------------------------------------------------
// four_bit_add
//   Registered 4-bit ripple-carry adder, {cout,sum} = a + b + cin, with a
//   LATENCY-deep pipeline (1 or 2 register stages, one result per cycle, no
//   backpressure). Outputs hold their last value when no result is produced.
//
//   Optional feature macro: FOUR_BIT_ADD_OVF_EN
//     defined   -> ovf = two's-complement overflow of the sampled operands
//     undefined -> ovf tied to 0, overflow logic omitted (port kept)
//
//   Parameters
//     LATENCY   : 1 or 2 register stages from input to output
//   Ports
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset, clears every stage
//     a, b      : 4-bit unsigned addends
//     cin       : carry-in
//     in_valid  : qualifies a/b/cin this cycle
//     sum       : registered result bits [3:0]
//     cout      : registered carry-out (bit 4)
//     out_valid : one-cycle pulse per accepted input, aligned with sum/cout
//     ovf       : registered signed overflow flag
// -----------------------------------------------------------------------------

// One bit slice of the ripple chain.
module four_bit_add_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_c,
  output logic o_s,
  output logic o_co
);
  assign o_s  = i_x ^ i_y ^ i_c;
  assign o_co = (i_x & i_y) | (i_c & (i_x ^ i_y));
endmodule

module four_bit_add #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic       in_valid,
  output logic [3:0] sum,
  output logic       cout,
  output logic       out_valid,
  output logic       ovf
);

  // Bit-slice operands/carries. Slices 1:0 always work on the live inputs;
  // slices 3:2 work on either live or stage-1 registered operands.
  logic [3:0] w_x, w_y, w_ci, w_s, w_co;

  // Values presented to the output register and its load enable.
  logic [3:0] w_sum_nxt;
  logic       w_ld;

  assign w_x[1:0] = a[1:0];
  assign w_y[1:0] = b[1:0];
  assign w_ci[0]  = cin;
  assign w_ci[1]  = w_co[0];
  assign w_ci[3]  = w_co[2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      four_bit_add_fa u_fa (
        .i_x  (w_x[gi]),
        .i_y  (w_y[gi]),
        .i_c  (w_ci[gi]),
        .o_s  (w_s[gi]),
        .o_co (w_co[gi])
      );
    end

    if (LATENCY == 1) begin : g_lat1
      // Whole chain evaluated in the input cycle.
      assign w_x[3:2]  = a[3:2];
      assign w_y[3:2]  = b[3:2];
      assign w_ci[2]   = w_co[1];
      assign w_sum_nxt = w_s;
      assign w_ld      = in_valid;
    end else begin : g_lat2
      // Stage 1 captures the low half result, the carry out of bit 1 and the
      // upper operand bits; stage 2 (output register) finishes bits 3:2.
      logic [1:0] r_s1_lo;
      logic       r_s1_c2;
      logic [1:0] r_s1_a_hi, r_s1_b_hi;
      logic       r_s1_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_s1_lo   <= 2'b0;
          r_s1_c2   <= 1'b0;
          r_s1_a_hi <= 2'b0;
          r_s1_b_hi <= 2'b0;
          r_s1_vld  <= 1'b0;
        end else begin
          r_s1_vld <= in_valid;
          if (in_valid) begin
            r_s1_lo   <= w_s[1:0];
            r_s1_c2   <= w_co[1];
            r_s1_a_hi <= a[3:2];
            r_s1_b_hi <= b[3:2];
          end
        end
      end

      assign w_x[3:2]  = r_s1_a_hi;
      assign w_y[3:2]  = r_s1_b_hi;
      assign w_ci[2]   = r_s1_c2;
      assign w_sum_nxt = {w_s[3:2], r_s1_lo};
      assign w_ld      = r_s1_vld;
    end
  endgenerate

  // Output stage: values only move when a result arrives, so they hold
  // across idle cycles; out_valid is a plain copy of the load enable.
  logic [3:0] r_sum;
  logic       r_cout;
  logic       r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= 4'b0;
      r_cout <= 1'b0;
      r_vld  <= 1'b0;
    end else begin
      r_vld <= w_ld;
      if (w_ld) begin
        r_sum  <= w_sum_nxt;
        r_cout <= w_co[3];
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_vld;

`ifdef FOUR_BIT_ADD_OVF_EN
  // Overflow: operands agree in sign but the result sign differs. w_x[3] /
  // w_y[3] are the sign bits of the same operands that produced w_s[3].
  logic w_ovf_nxt;
  logic r_ovf;

  assign w_ovf_nxt = (w_x[3] == w_y[3]) && (w_s[3] != w_x[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_ovf <= 1'b0;
    else if (w_ld) r_ovf <= w_ovf_nxt;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_four_bit_add.sv
module tb_four_bit_add;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a = 4'd0, b = 4'd0;
  logic       cin = 1'b0, in_valid = 1'b0;

  logic [3:0] sum1, sum2;
  logic       cout1, cout2, ov1, ov2, vld1, vld2;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  four_bit_add #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum1), .cout(cout1), .out_valid(vld1), .ovf(ov1)
  );

  four_bit_add #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .in_valid(in_valid),
    .sum(sum2), .cout(cout2), .out_valid(vld2), .ovf(ov2)
  );

  // Reference model: history of inputs sampled at each edge; the output of
  // a latency-L adder after edge k is the arithmetic result of the input
  // sampled at edge k-L+1 (if valid), otherwise the previous value is held.
  typedef struct { logic [3:0] a, b; logic c, v; } rec_t;
  rec_t hist[$];
  logic [3:0] es [1:2];
  logic       ec [1:2], eo [1:2], ev [1:2];

  task automatic model_reset();
    hist.delete();
    for (int l = 1; l <= 2; l++) begin
      es[l] = 4'd0; ec[l] = 1'b0; eo[l] = 1'b0; ev[l] = 1'b0;
    end
  endtask

  task automatic model_edge(input rec_t r);
    hist.push_back(r);
    for (int l = 1; l <= 2; l++) begin
      if (hist.size() >= l) begin
        rec_t h;
        int   t;
        h = hist[hist.size() - l];
        ev[l] = h.v;
        if (h.v) begin
          t = int'(h.a) + int'(h.b) + int'(h.c);
          es[l] = t[3:0];
          ec[l] = t[4];
`ifdef FOUR_BIT_ADD_OVF_EN
          eo[l] = (h.a[3] == h.b[3]) && (t[3] != h.a[3]);
`else
          eo[l] = 1'b0;
`endif
        end
      end else begin
        ev[l] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".l1.sum"},  {1'b0, sum1},  {1'b0, es[1]});
    chk({tag, ".l1.cout"}, {4'b0, cout1}, {4'b0, ec[1]});
    chk({tag, ".l1.vld"},  {4'b0, vld1},  {4'b0, ev[1]});
    chk({tag, ".l1.ovf"},  {4'b0, ov1},   {4'b0, eo[1]});
    chk({tag, ".l2.sum"},  {1'b0, sum2},  {1'b0, es[2]});
    chk({tag, ".l2.cout"}, {4'b0, cout2}, {4'b0, ec[2]});
    chk({tag, ".l2.vld"},  {4'b0, vld2},  {4'b0, ev[2]});
    chk({tag, ".l2.ovf"},  {4'b0, ov2},   {4'b0, eo[2]});
  endtask

  // Drive one cycle of inputs, let the edge sample them, check #1 later.
  task automatic step(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                      input logic ic, input logic iv);
    rec_t r;
    a = ia; b = ib; cin = ic; in_valid = iv;
    r.a = ia; r.b = ib; r.c = ic; r.v = iv;
    @(posedge clk);
    model_edge(r);
    #1;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    // Asynchronous reset: outputs forced low before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk_all("reset_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First operation after reset: 0+0.
    step("zero", 4'd0, 4'd0, 1'b0, 1'b1);
    step("zero_t", 4'd0, 4'd0, 1'b0, 1'b0);

    // Back-to-back stream: sums 1,3,5,7,9.
    for (int i = 0; i < 5; i++) step("stream", 4'(i), 4'(i + 1), 1'b0, 1'b1);
    step("stream_t", 4'd0, 4'd0, 1'b0, 1'b0);
    step("stream_t", 4'd0, 4'd0, 1'b0, 1'b0);

    // Wrap-around corners, with direct constant checks on the L=1 result.
    step("wrap15_1", 4'd15, 4'd1, 1'b0, 1'b1);
    chk("wrap15_1.const", {cout1, sum1}, 5'd16);
    step("wrap15_15_1", 4'd15, 4'd15, 1'b1, 1'b1);
    chk("wrap15_15_1.const", {cout1, sum1}, 5'd31);
    step("wrap_t", 4'd0, 4'd0, 1'b0, 1'b0);

    // Overflow corners.
    step("ovf_7_1", 4'd7, 4'd1, 1'b0, 1'b1);
    step("ovf_8_8", 4'd8, 4'd8, 1'b0, 1'b1);
    step("ovf_3_2", 4'd3, 4'd2, 1'b0, 1'b1);
    step("ovf_t", 4'd0, 4'd0, 1'b0, 1'b0);

    // Gapped valid pattern: results follow the pattern, outputs hold between.
    step("gap", 4'd5, 4'd6, 1'b0, 1'b1);
    step("gap", 4'd1, 4'd1, 1'b1, 1'b0);
    step("gap", 4'd2, 4'd9, 1'b0, 1'b0);
    step("gap", 4'd12, 4'd3, 1'b1, 1'b1);
    step("gap", 4'd7, 4'd7, 1'b0, 1'b0);
    step("gap", 4'd9, 4'd9, 1'b1, 1'b1);
    step("gap", 4'd4, 4'd4, 1'b0, 1'b0);
    step("gap", 4'd4, 4'd4, 1'b0, 1'b0);

    // Random stimulus.
    for (int i = 0; i < 60; i++)
      step("rand", 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    step("rand_t", 4'd0, 4'd0, 1'b0, 1'b0);

    // Reset one cycle after an accepted input: in-flight result discarded.
    step("pre_rst", 4'd9, 4'd4, 1'b0, 1'b1);
    a = 4'd5; b = 4'd5; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_all("mid_rst");
    @(posedge clk);
    #1;
    chk_all("in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 4'd0, 4'd0, 1'b0, 1'b0);
    step("post_rst", 4'd0, 4'd0, 1'b0, 1'b0);
    step("post_rst", 4'd0, 4'd0, 1'b0, 1'b0);

    // First input after reset processed normally.
    step("first", 4'd3, 4'd4, 1'b0, 1'b1);
    step("first_t", 4'd0, 4'd0, 1'b0, 1'b0);
    step("first_t", 4'd0, 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
